life_grid_engine: RTL

Parametrised Conway's Game of Life engine and successor to the fixed-size tt_um_game_of_life core. It holds a WIDTH x HEIGHT cell grid. The grid is loaded serially, and the engine advances it one generation per step or continuously in run mode. Each generation is computed row-serially into a shadow buffer and then committed in one cycle. Edges are selectable per generation: toroidal wrap or dead boundary. The engine reports a generation count and stable/extinct status, and the grid can be read back one row at a time.

---
 rtl/life_grid_engine.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/life_grid_engine.sv
// -----------------------------------------------------------------------------
// life_grid_engine
//
// Conway's Game of Life engine for a WIDTH x HEIGHT cell grid.
//
// The grid is loaded serially in row-major order. One generation is computed
// one row per cycle into a shadow buffer, then committed to the visible grid
// in a single cycle, so readback never exposes a half-updated generation.
// Edges are either toroidal (wrap=1) or a dead boundary (wrap=0). The choice
// is latched at the start of every generation.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   load_start    pulse: clear grid/counter/status and enter LOAD
//   load_valid    qualifies load_bit while loading
//   load_bit      cell value; cell k = row*WIDTH + col
//   step          pulse: compute exactly one generation (dropped while busy)
//   run           level: keep computing generations until the grid is stable
//   wrap          1 = toroidal edges, 0 = dead boundary
//   rd_row        readback row select
//   rd_data       registered copy of committed row rd_row (0 if rd_row >= HEIGHT)
//   busy          high in LOAD, COMPUTE and COMMIT
//   gen_count     generations committed since the last load (wraps)
//   stable        last commit equalled its predecessor
//   extinct       last commit was all-dead
//   done          one-cycle pulse in the cycle after each commit
// -----------------------------------------------------------------------------
module life_grid_engine #(
  parameter  int WIDTH  = 8,
  parameter  int HEIGHT = 8,
  parameter  int GEN_W  = 8,
  localparam int RW     = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_bit,
  input  logic             step,
  input  logic             run,
  input  logic             wrap,
  input  logic [RW-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  // Number of addressable rows on rd_row; rows past HEIGHT read as dead.
  localparam int HP = 1 << RW;

  typedef logic [WIDTH-1:0]  row_t;
  typedef row_t [HEIGHT-1:0] grid_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_COMMIT
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,   state_d;
  grid_t            grid_q,    grid_d;
  grid_t            shadow_q,  shadow_d;
  logic [RW-1:0]    row_q,     row_d;     // load row / compute row pointer
  logic [CW-1:0]    col_q,     col_d;     // load column
  logic             wrap_q,    wrap_d;    // edge mode of the generation in flight
  row_t             rd_data_q, rd_data_d;
  logic [GEN_W-1:0] gen_q,     gen_d;
  logic             stable_q,  stable_d;
  logic             extinct_q, extinct_d;
  logic             done_q,    done_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Row with one pad cell on each side: bit 0 is the left neighbour of
  // column 0, bit WIDTH+1 the right neighbour of column WIDTH-1. Column c of
  // the row sits at bit c+1, so its three horizontal neighbours are [c +: 3].
  function automatic logic [WIDTH+1:0] extend_row(input row_t r, input logic wr);
    return {wr & r[0], r, wr & r[WIDTH-1]};
  endfunction

  function automatic logic life_rule(input logic alive, input logic [7:0] nbrs);
    logic [3:0] n;
    n = 4'($countones(nbrs));
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

  // ---------------------------------------------------------------------------
  // Committed grid widened to every rd_row code, so both readback and row
  // lookups can index it freely.
  // ---------------------------------------------------------------------------
  row_t [HP-1:0] grid_pad;

  always_comb begin
    grid_pad = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      grid_pad[i] = grid_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state row for the row under the compute pointer
  // ---------------------------------------------------------------------------
  logic [RW-1:0]    up_idx, dn_idx;
  logic             up_ok, dn_ok;
  logic [WIDTH+1:0] up_ext, mid_ext, dn_ext;
  row_t             next_row;

  always_comb begin
    // Vertical neighbours: wrap to the opposite edge, or read as dead.
    up_idx  = (row_q == '0) ? RW'(HEIGHT - 1) : row_q - 1'b1;
    dn_idx  = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
    up_ok   = wrap_q || (row_q != '0);
    dn_ok   = wrap_q || (row_q != RW'(HEIGHT - 1));
    up_ext  = extend_row(up_ok ? grid_pad[up_idx] : '0, wrap_q);
    mid_ext = extend_row(grid_pad[row_q], wrap_q);
    dn_ext  = extend_row(dn_ok ? grid_pad[dn_idx] : '0, wrap_q);
    next_row = '0;
    for (int c = 0; c < WIDTH; c++) begin
      next_row[c] = life_rule(mid_ext[c+1],
                              {up_ext[c +: 3], mid_ext[c], mid_ext[c+2], dn_ext[c +: 3]});
    end
  end

  // ---------------------------------------------------------------------------
  // Control and datapath next-state
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' and start by assigning every
  // output a default, so no path leaves a signal unassigned and no latch is
  // inferred; the clocked block below uses only non-blocking '<='.
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    shadow_d  = shadow_q;
    row_d     = row_q;
    col_d     = col_q;
    wrap_d    = wrap_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    done_d    = 1'b0;
    rd_data_d = grid_pad[rd_row];

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          grid_d    = '0;
          row_d     = '0;
          col_d     = '0;
          gen_d     = '0;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
          state_d   = S_LOAD;
        end else if (step || (run && !stable_q)) begin
          // A level-high run does not restart on a grid already known to be
          // stable; that is what lets run mode halt by itself.
          wrap_d  = wrap;
          row_d   = '0;
          state_d = S_COMPUTE;
        end
      end

      S_LOAD: begin
        if (load_valid) begin
          grid_d[row_q][col_q] = load_bit;
          if (col_q == CW'(WIDTH - 1)) begin
            col_d = '0;
            if (row_q == RW'(HEIGHT - 1)) begin
              state_d = S_IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      S_COMPUTE: begin
        shadow_d[row_q] = next_row;
        if (row_q == RW'(HEIGHT - 1)) begin
          state_d = S_COMMIT;
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      S_COMMIT: begin
        stable_d  = (shadow_q == grid_q);
        extinct_d = (shadow_q == '0);
        grid_d    = shadow_q;
        gen_d     = gen_q + 1'b1;
        done_d    = 1'b1;
        if (run && !stable_d) begin
          wrap_d  = wrap;
          row_d   = '0;
          state_d = S_COMPUTE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the grid and shadow arrays are reset along with the control state;
  // the engine must come out of reset with a defined, all-dead grid and any
  // generation in flight discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      shadow_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wrap_q    <= 1'b0;
      rd_data_q <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      shadow_q  <= shadow_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wrap_q    <= wrap_d;
      rd_data_q <= rd_data_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      done_q    <= done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q != S_IDLE);
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign done      = done_q;

endmodule
